// File: rtl/vga_char_render.sv
// rtl/vga_char_render.sv - text-mode VRAM/font pixel pipeline, fixed 4-cycle latency
// Optional blinking cursor inversion: define VGA_CURSOR_EN
module vga_char_render #(
  parameter logic [23:0] FG_RGB = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB = 24'h000000
`ifdef VGA_CURSOR_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        vga_hs_i,
  input  logic        vga_vs_i,
  input  logic        vga_blank_N_i,
  input  logic        envalid_i,
  input  logic [12:0] char_addr_i,
  input  logic [2:0]  x_addr_i,
  input  logic [2:0]  y_addr_i,
`ifdef VGA_CURSOR_EN
  input  logic [12:0] cursor_addr_i,
`endif
  output logic [12:0] vram_addr_o,
  input  logic [7:0]  vram_data_i,
  output logic [10:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output logic [7:0]  vga_r_o,
  output logic [7:0]  vga_g_o,
  output logic [7:0]  vga_b_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        vga_blank_N_o,
  output logic        vga_sync_N_o
);

  // Per-pixel side information travelling alongside the VRAM/ROM reads.
  // Stage numbers count edges after the input sample (d1 = after E0).
  logic [2:0]  x_d1, x_d2, x_d3;
  logic [2:0]  y_d1, y_d2;
  logic        en_d1, en_d2, en_d3;
  logic        hs_d1, hs_d2, hs_d3;
  logic        vs_d1, vs_d2, vs_d3;
  logic        blank_d1, blank_d2, blank_d3;
  logic [23:0] rgb;
  logic        pix_raw;
  logic        pix;

  // Delay line plus the registered outputs; reset leaves syncs inactive and video black.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vram_addr_o   <= 13'd0;
      x_d1          <= 3'd0;
      x_d2          <= 3'd0;
      x_d3          <= 3'd0;
      y_d1          <= 3'd0;
      y_d2          <= 3'd0;
      en_d1         <= 1'b0;
      en_d2         <= 1'b0;
      en_d3         <= 1'b0;
      hs_d1         <= 1'b1;
      hs_d2         <= 1'b1;
      hs_d3         <= 1'b1;
      vs_d1         <= 1'b1;
      vs_d2         <= 1'b1;
      vs_d3         <= 1'b1;
      blank_d1      <= 1'b0;
      blank_d2      <= 1'b0;
      blank_d3      <= 1'b0;
      rgb           <= 24'h0;
      vga_hs_o      <= 1'b1;
      vga_vs_o      <= 1'b1;
      vga_blank_N_o <= 1'b0;
    end else begin
      vram_addr_o   <= char_addr_i;
      x_d1          <= x_addr_i;
      x_d2          <= x_d1;
      x_d3          <= x_d2;
      y_d1          <= y_addr_i;
      y_d2          <= y_d1;
      en_d1         <= envalid_i;
      en_d2         <= en_d1;
      en_d3         <= en_d2;
      hs_d1         <= vga_hs_i;
      hs_d2         <= hs_d1;
      hs_d3         <= hs_d2;
      vs_d1         <= vga_vs_i;
      vs_d2         <= vs_d1;
      vs_d3         <= vs_d2;
      blank_d1      <= vga_blank_N_i;
      blank_d2      <= blank_d1;
      blank_d3      <= blank_d2;
      rgb           <= en_d3 ? (pix ? FG_RGB : BG_RGB) : 24'h0;
      vga_hs_o      <= hs_d3;
      vga_vs_o      <= vs_d3;
      vga_blank_N_o <= blank_d3;
    end
  end

  // VRAM data feeds the ROM address directly so the ROM read overlaps the next stage.
  assign font_addr_o = {vram_data_i, y_d2};

  // Glyph rows store the leftmost pixel in bit 7.
  assign pix_raw = font_data_i[3'd7 - x_d3];

`ifdef VGA_CURSOR_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             vs_prev;
  logic             vs_rise;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_on;
  logic             hit_d1, hit_d2, hit_d3;

  // A frame boundary is the end of the vsync pulse (low to high).
  assign vs_rise = vga_vs_i & ~vs_prev;

  // Frame counter, blink phase and the cursor-hit flag riding the delay line.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vs_prev   <= 1'b1;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      hit_d3    <= 1'b0;
    end else begin
      vs_prev <= vga_vs_i;
      if (vs_rise) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      hit_d1 <= envalid_i & (char_addr_i == cursor_addr_i);
      hit_d2 <= hit_d1;
      hit_d3 <= hit_d2;
    end
  end

  assign pix = pix_raw ^ (hit_d3 & blink_on);
`else
  assign pix = pix_raw;
`endif

  assign vga_r_o      = rgb[23:16];
  assign vga_g_o      = rgb[15:8];
  assign vga_b_o      = rgb[7:0];
  assign vga_sync_N_o = 1'b0;

endmodule

// File: tb/tb_vga_char_render.sv
// tb/tb_vga_char_render.sv - self-checking bench for vga_char_render (cursor tests with VGA_CURSOR_EN)
module tb_vga_char_render;

  localparam logic [23:0] FG = 24'hF0A055;
  localparam logic [23:0] BG = 24'h102030;
  localparam int BF = 2;
  localparam int MAXN = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_i = 1'b1;
  logic        vs_i = 1'b1;
  logic        blank_i = 1'b0;
  logic        en_i = 1'b0;
  logic [12:0] char_i = 13'd0;
  logic [2:0]  x_i = 3'd0;
  logic [2:0]  y_i = 3'd0;
  logic [12:0] cursor_addr = 13'd5;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data = 8'h00;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [7:0]  r, g, b;
  logic        hs_o, vs_o, blank_o, sync_o;
  logic [27:0] dut_vec;

  int checks = 0;
  int errors = 0;
  int hs_low_cnt = 0;

  logic [7:0] vram_mem [8192];

  always #20 clk = ~clk;

  vga_char_render #(
    .FG_RGB(FG),
    .BG_RGB(BG)
`ifdef VGA_CURSOR_EN
    ,
    .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .vga_hs_i(hs_i),
    .vga_vs_i(vs_i),
    .vga_blank_N_i(blank_i),
    .envalid_i(en_i),
    .char_addr_i(char_i),
    .x_addr_i(x_i),
    .y_addr_i(y_i),
`ifdef VGA_CURSOR_EN
    .cursor_addr_i(cursor_addr),
`endif
    .vram_addr_o(vram_addr),
    .vram_data_i(vram_data),
    .font_addr_o(font_addr),
    .font_data_i(font_data),
    .vga_r_o(r),
    .vga_g_o(g),
    .vga_b_o(b),
    .vga_hs_o(hs_o),
    .vga_vs_o(vs_o),
    .vga_blank_N_o(blank_o),
    .vga_sync_N_o(sync_o)
  );

  assign dut_vec = {r, g, b, hs_o, vs_o, blank_o, sync_o};

  function automatic logic [7:0] rom_row(input logic [10:0] a);
    if (a == 11'h20B) return 8'hA1;
    else if (a[10:3] == 8'hFF) return 8'hFF;
    else if (a[10:3] == 8'h20) return 8'h00;
    else return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous VRAM and font ROM, one cycle of read latency each.
  always @(posedge clk) begin
    vram_data <= vram_mem[vram_addr];
    font_data <= rom_row(font_addr);
  end

  // Input history per clock edge, plus frame count since reset.
  logic        h_rst [MAXN];
  logic        h_en [MAXN];
  logic [12:0] h_char [MAXN];
  logic [2:0]  h_x [MAXN];
  logic [2:0]  h_y [MAXN];
  logic        h_hs [MAXN];
  logic        h_vs [MAXN];
  logic        h_bl [MAXN];
  int          h_frames [MAXN];
  int          n = 0;
  int          frames = 0;
  logic        vs_last = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      frames = 0;
      vs_last = 1'b1;
    end else begin
      if (!vs_last && vs_i) frames++;
      vs_last = vs_i;
    end
    if (n < MAXN) begin
      h_rst[n] = rst_n; h_en[n] = en_i; h_char[n] = char_i;
      h_x[n] = x_i; h_y[n] = y_i; h_hs[n] = hs_i; h_vs[n] = vs_i;
      h_bl[n] = blank_i; h_frames[n] = frames;
    end
    n++;
  end

  // Output after edge j: the pixel sampled at edge j-3, unless reset touched that window.
  function automatic logic [27:0] model_out(input int j);
    int k;
    logic [7:0] code;
    logic [7:0] row;
    logic bitv;
    logic [23:0] rgb;
    if (j < 3) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = j - 3; i <= j; i++)
      if (!h_rst[i]) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    k = j - 3;
    code = vram_mem[h_char[k]];
    row = rom_row({code, h_y[k]});
    bitv = row[7 - int'(h_x[k])];
`ifdef VGA_CURSOR_EN
    if (h_en[k] && h_char[k] == cursor_addr && ((h_frames[j-1] / BF) % 2 == 0)) bitv = ~bitv;
`endif
    rgb = h_en[k] ? (bitv ? FG : BG) : 24'h0;
    return {rgb, h_hs[k], h_vs[k], h_bl[k], 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!hs_o) hs_low_cnt++;
    if (n >= 1 && n <= MAXN) chk("pipe", {4'h0, dut_vec}, {4'h0, model_out(n - 1)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic en, input logic [12:0] ch, input logic [2:0] x, input logic [2:0] y);
    en_i = en; char_i = ch; x_i = x; y_i = y;
  endtask

  logic [23:0] lit [8];

  initial begin
    for (int i = 0; i < 8192; i++) vram_mem[i] = 8'h33;
    vram_mem[0] = 8'hFF;
    vram_mem[81] = 8'h41;
    vram_mem[5] = 8'h20;
    vram_mem[6] = 8'h20;
    lit[0] = FG; lit[1] = BG; lit[2] = FG; lit[3] = BG;
    lit[4] = BG; lit[5] = BG; lit[6] = BG; lit[7] = FG;

    // Reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_out", {4'h0, r, g, b, hs_o, vs_o, blank_o, sync_o}, {4'h0, 24'h0, 4'b1100});
    end
    rst_n = 1'b1;
    blank_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("release_blank", {31'h0, blank_o}, {31'h0, (i >= 3)});
    end

    // One glyph row of cell 81, row 3
    for (int i = 0; i < 11; i++) begin
      if (i < 8) set_px(1'b1, 13'd81, 3'(i), 3'd3);
      else set_px(1'b0, 13'd0, 3'd0, 3'd0);
      step();
      if (i == 0) chk("vram_addr", {19'h0, vram_addr}, 32'd81);
      if (i == 1) chk("font_addr", {21'h0, font_addr}, 32'h20B);
      if (i >= 3) chk("glyph_rgb", {8'h0, r, g, b}, {8'h0, lit[i-3]});
    end

    // 96-cycle hsync pulse
    hs_low_cnt = 0;
    hs_i = 1'b0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (i == 2) chk("hs_not_yet", {31'h0, hs_o}, 32'd1);
      if (i == 3) chk("hs_shifted", {31'h0, hs_o}, 32'd0);
    end
    hs_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("hs_width", hs_low_cnt, 32'd96);

    // Inactive pixels with an all-ones glyph stay black; active ones are foreground
    for (int i = 0; i < 10; i++) begin
      set_px(1'b0, 13'd0, 3'(i), 3'd1);
      step();
      if (i >= 3) chk("inactive_black", {8'h0, r, g, b}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      set_px(1'b1, 13'd0, 3'(i), 3'd2);
      step();
    end
    set_px(1'b0, 13'd0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of an active line
    hs_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_px(1'b1, 13'd81, 3'(i), 3'd3);
      step();
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_px(1'b1, 13'd81, 3'(i + 6), 3'd3);
      step();
      chk("midreset_out", {4'h0, r, g, b, hs_o, vs_o, blank_o}, {5'h0, 24'h0, 3'b110});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_px(1'b1, 13'd81, 3'(i), 3'd3);
      step();
      if (i < 3) chk("resume_black", {8'h0, r, g, b}, 32'h0);
      if (i >= 3) chk("resume_rgb", {8'h0, r, g, b}, {8'h0, lit[i-3]});
    end
    hs_i = 1'b1;
    set_px(1'b0, 13'd0, 3'd0, 3'd0);
    for (int i = 0; i < 6; i++) step();

`ifdef VGA_CURSOR_EN
    // Cursor on cell 5 over six frames, blink half-period of two frames
    for (int f = 0; f < 6; f++) begin
      set_px(1'b1, 13'd5, 3'd0, 3'd0);
      step();
      set_px(1'b1, 13'd6, 3'd0, 3'd0);
      step();
      set_px(1'b0, 13'd0, 3'd0, 3'd0);
      step();
      step();
      chk("cursor_cell", {8'h0, r, g, b}, {8'h0, ((f / 2) % 2 == 0) ? FG : BG});
      step();
      chk("other_cell", {8'h0, r, g, b}, {8'h0, BG});
      vs_i = 1'b0;
      step();
      step();
      vs_i = 1'b1;
      step();
      step();
    end
`endif

    for (int i = 0; i < 6; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
